// File: rtl/uart_mmio_fifo_pkg.sv
// Shared register map, status/control bit positions and TX FSM encoding for the
// memory-mapped UART front end.
package uart_mmio_pkg;

    localparam logic [3:0] OFF_DATA   = 4'h0;
    localparam logic [3:0] OFF_STATUS = 4'h4;
    localparam logic [3:0] OFF_CTRL   = 4'h8;

    localparam int ST_TX_FULL    = 0;
    localparam int ST_TX_EMPTY   = 1;
    localparam int ST_RX_EMPTY   = 2;
    localparam int ST_RX_FULL    = 3;
    localparam int ST_RX_OVF     = 4;
    localparam int ST_TX_OVF     = 5;
    localparam int ST_RX_BRK     = 6;
    localparam int ST_RX_CNT_LSB = 8;
    localparam int ST_TX_CNT_LSB = 16;

    localparam int CTRL_RX_IE = 0;
    localparam int CTRL_TX_IE = 1;

    typedef enum logic [1:0] {
        TX_IDLE      = 2'd0,
        TX_WAIT_BUSY = 2'd1,
        TX_WAIT_DONE = 2'd2
    } tx_state_e;

    localparam logic [2:0] TX_BUSY_TIMEOUT = 3'd4;

endpackage

// File: rtl/uart_mmio_fifo_if.sv
// CPU load/store port of the UART register window.
interface uart_mmio_fifo_if;
    logic [63:0] uart_addr;
    logic [31:0] uart_write_data;
    logic        uart_wen;
    logic        uart_ren;
    logic [31:0] uart_read_data;

    modport master (
        output uart_addr, uart_write_data, uart_wen, uart_ren,
        input  uart_read_data
    );

    modport slave (
        input  uart_addr, uart_write_data, uart_wen, uart_ren,
        output uart_read_data
    );
endinterface

// File: rtl/uart_mmio_fifo_sync_fifo.sv
// Single-clock FIFO with wrap-bit pointers; a pop on a full FIFO frees the slot
// for a push in the same cycle.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         din,
    output logic [WIDTH-1:0]         dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);

    logic [AW:0]      wptr_r;
    logic [AW:0]      rptr_r;
    logic [WIDTH-1:0] mem_r [DEPTH];
    logic             pop_ok_s;
    logic             push_ok_s;

    assign empty     = (wptr_r == rptr_r);
    assign full      = (wptr_r[AW] != rptr_r[AW]) && (wptr_r[AW-1:0] == rptr_r[AW-1:0]);
    assign count     = wptr_r - rptr_r;
    assign dout      = mem_r[rptr_r[AW-1:0]];
    assign pop_ok_s  = pop & ~empty;
    assign push_ok_s = push & (~full | pop_ok_s);

    // Pointer update; reset flushes the FIFO.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr_r <= '0;
            rptr_r <= '0;
        end else begin
            if (push_ok_s) wptr_r <= wptr_r + (AW+1)'(1);
            if (pop_ok_s)  rptr_r <= rptr_r + (AW+1)'(1);
        end
    end

    // Storage array, written only on an accepted push.
    always_ff @(posedge clk) begin
        if (push_ok_s) mem_r[wptr_r[AW-1:0]] <= din;
    end
endmodule

// File: rtl/uart_mmio_fifo.sv
// UART MMIO front end: TX/RX byte FIFOs, STATUS/CTRL registers, launch FSM
// pacing uart_tx by its busy flag, and a registered level interrupt.
module uart_mmio_fifo
    import uart_mmio_pkg::*;
#(
    parameter logic [63:0] BASE_ADDR    = 64'h1000_0000,
    parameter int          FIFO_DEPTH   = 16,
    parameter int          PAYLOAD_BITS = 8
) (
    input  logic                    clk,
    input  logic                    rst_n,
    uart_mmio_fifo_if.slave         bus,
    output logic [PAYLOAD_BITS-1:0] tx_data,
    output logic                    tx_en,
    input  logic                    tx_busy,
    input  logic [PAYLOAD_BITS-1:0] rx_data,
    input  logic                    rx_valid,
    input  logic                    rx_break,
    output logic                    irq
);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    logic                    hit_s, wr_s, rd_s, rd_any_s;
    logic [3:0]              off_s;
    logic                    tx_push_s, tx_pop_s, tx_full_s, tx_empty_s;
    logic                    rx_pop_s, rx_full_s, rx_empty_s;
    logic [PAYLOAD_BITS-1:0] tx_dout_s, rx_dout_s;
    logic [CW-1:0]           tx_count_s, rx_count_s;
    logic                    wr_status_s, rx_ovf_set_s, tx_ovf_set_s;
    logic [31:0]             rd_data_s;
    logic [31:0]             rd_data_r;
    logic                    rx_ovf_r, tx_ovf_r, rx_brk_r, rx_ie_r, tx_ie_r, irq_r;
    tx_state_e               state_r;
    logic [2:0]              tmo_r;
    logic                    tx_en_r;
    logic [PAYLOAD_BITS-1:0] tx_data_r;
    logic                    unused_wdata_s;

    function automatic logic [31:0] pack_status(
        input logic tx_full, tx_empty, rx_empty, rx_full, rx_ovf, tx_ovf, rx_brk,
        input logic [CW-1:0] rx_cnt, tx_cnt
    );
        logic [31:0] s;
        s = 32'h0;
        s[ST_TX_FULL]  = tx_full;
        s[ST_TX_EMPTY] = tx_empty;
        s[ST_RX_EMPTY] = rx_empty;
        s[ST_RX_FULL]  = rx_full;
        s[ST_RX_OVF]   = rx_ovf;
        s[ST_TX_OVF]   = tx_ovf;
        s[ST_RX_BRK]   = rx_brk;
        s[ST_RX_CNT_LSB +: 8] = 8'(rx_cnt);
        s[ST_TX_CNT_LSB +: 8] = 8'(tx_cnt);
        return s;
    endfunction

    // A simultaneous write and read resolves in favour of the write.
    assign hit_s          = (bus.uart_addr[63:4] == BASE_ADDR[63:4]);
    assign off_s          = bus.uart_addr[3:0];
    assign rd_any_s       = bus.uart_ren & ~bus.uart_wen;
    assign wr_s           = bus.uart_wen & hit_s;
    assign rd_s           = rd_any_s & hit_s;
    assign tx_push_s      = wr_s & (off_s == OFF_DATA);
    assign rx_pop_s       = rd_s & (off_s == OFF_DATA) & ~rx_empty_s;
    assign wr_status_s    = wr_s & (off_s == OFF_STATUS);
    assign tx_pop_s       = (state_r == TX_IDLE) & ~tx_empty_s & ~tx_busy;
    assign rx_ovf_set_s   = rx_valid & rx_full_s & ~rx_pop_s;
    assign tx_ovf_set_s   = tx_push_s & tx_full_s & ~tx_pop_s;
    assign unused_wdata_s = ^bus.uart_write_data[31:PAYLOAD_BITS];

    sync_fifo #(.WIDTH(PAYLOAD_BITS), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
        .clk(clk), .rst_n(rst_n), .push(tx_push_s), .pop(tx_pop_s),
        .din(bus.uart_write_data[PAYLOAD_BITS-1:0]), .dout(tx_dout_s),
        .full(tx_full_s), .empty(tx_empty_s), .count(tx_count_s)
    );

    sync_fifo #(.WIDTH(PAYLOAD_BITS), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
        .clk(clk), .rst_n(rst_n), .push(rx_valid), .pop(rx_pop_s),
        .din(rx_data), .dout(rx_dout_s),
        .full(rx_full_s), .empty(rx_empty_s), .count(rx_count_s)
    );

    // Read mux; misses and reserved offsets return zero.
    always_comb begin
        rd_data_s = 32'h0;
        if (hit_s) begin
            case (off_s)
                OFF_DATA:   rd_data_s = rx_empty_s ? 32'h0 : 32'(rx_dout_s);
                OFF_STATUS: rd_data_s = pack_status(tx_full_s, tx_empty_s, rx_empty_s, rx_full_s,
                                                    rx_ovf_r, tx_ovf_r, rx_brk_r, rx_count_s, tx_count_s);
                OFF_CTRL:   rd_data_s = {30'h0, tx_ie_r, rx_ie_r};
                default:    rd_data_s = 32'h0;
            endcase
        end else begin
            rd_data_s = 32'h0;
        end
    end

    // Registered load data, updated only by a load that was not overridden by a store.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)        rd_data_r <= 32'h0;
        else if (rd_any_s) rd_data_r <= rd_data_s;
        else               rd_data_r <= rd_data_r;
    end

    // Sticky error flags (W1C, a same-cycle set wins) and CTRL enables.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_ovf_r <= 1'b0;
            tx_ovf_r <= 1'b0;
            rx_brk_r <= 1'b0;
            rx_ie_r  <= 1'b0;
            tx_ie_r  <= 1'b0;
        end else begin
            if (rx_ovf_set_s)                                  rx_ovf_r <= 1'b1;
            else if (wr_status_s && bus.uart_write_data[ST_RX_OVF]) rx_ovf_r <= 1'b0;
            if (tx_ovf_set_s)                                  tx_ovf_r <= 1'b1;
            else if (wr_status_s && bus.uart_write_data[ST_TX_OVF]) tx_ovf_r <= 1'b0;
            if (rx_break)                                      rx_brk_r <= 1'b1;
            else if (wr_status_s && bus.uart_write_data[ST_RX_BRK]) rx_brk_r <= 1'b0;
            if (wr_s && (off_s == OFF_CTRL)) begin
                rx_ie_r <= bus.uart_write_data[CTRL_RX_IE];
                tx_ie_r <= bus.uart_write_data[CTRL_TX_IE];
            end
        end
    end

    // Level interrupt, one cycle behind the FIFO state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) irq_r <= 1'b0;
        else        irq_r <= (rx_ie_r & ~rx_empty_s) | (tx_ie_r & tx_empty_s);
    end

    // Launch FSM; the WAIT_BUSY timeout recovers from a launch uart_tx never saw.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r   <= TX_IDLE;
            tmo_r     <= 3'd0;
            tx_en_r   <= 1'b0;
            tx_data_r <= '0;
        end else begin
            case (state_r)
                TX_IDLE: begin
                    tmo_r <= 3'd0;
                    if (tx_pop_s) begin
                        tx_en_r   <= 1'b1;
                        tx_data_r <= tx_dout_s;
                        state_r   <= TX_WAIT_BUSY;
                    end else begin
                        tx_en_r   <= 1'b0;
                    end
                end
                TX_WAIT_BUSY: begin
                    tx_en_r <= 1'b0;
                    if (tx_busy)                                state_r <= TX_WAIT_DONE;
                    else if (tmo_r == TX_BUSY_TIMEOUT - 3'd1)   state_r <= TX_IDLE;
                    else                                        tmo_r   <= tmo_r + 3'd1;
                end
                TX_WAIT_DONE: begin
                    tx_en_r <= 1'b0;
                    if (!tx_busy) state_r <= TX_IDLE;
                    else          state_r <= TX_WAIT_DONE;
                end
                default: begin
                    tx_en_r <= 1'b0;
                    state_r <= TX_IDLE;
                end
            endcase
        end
    end

    assign bus.uart_read_data = rd_data_r;
    assign tx_en              = tx_en_r;
    assign tx_data            = tx_data_r;
    assign irq                = irq_r;
endmodule

// File: tb/tb_uart_mmio_fifo.sv
// Directed bench for uart_mmio_fifo: register table plus TX/RX/IRQ/reset sequences
// against a simple uart_tx busy model.
module tb_uart_mmio_fifo;
    localparam logic [63:0] BASE   = 64'h1000_0000;
    localparam logic [63:0] A_DATA = BASE + 64'h0;
    localparam logic [63:0] A_STAT = BASE + 64'h4;
    localparam logic [63:0] A_CTRL = BASE + 64'h8;
    localparam logic [63:0] A_RSVD = BASE + 64'hC;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] tx_data, rx_data;
    logic       tx_en, tx_busy, rx_valid, rx_break, irq;

    always #5 clk = ~clk;

    uart_mmio_fifo_if bus();

    uart_mmio_fifo #(.BASE_ADDR(BASE), .FIFO_DEPTH(16), .PAYLOAD_BITS(8)) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus),
        .tx_data(tx_data), .tx_en(tx_en), .tx_busy(tx_busy),
        .rx_data(rx_data), .rx_valid(rx_valid), .rx_break(rx_break), .irq(irq)
    );

    int total = 0;
    int bad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // uart_tx model: busy for 10 cycles starting one cycle after a launch.
    logic busy_hold = 1'b0;
    logic model_en  = 1'b1;
    int   busy_cnt  = 0;
    always @(posedge clk) begin
        if (tx_en && model_en) busy_cnt <= 10;
        else if (busy_cnt > 0) busy_cnt <= busy_cnt - 1;
    end
    assign tx_busy = busy_hold | (busy_cnt != 0);

    // Launch monitor.
    int         cyc = 0;
    int         last_pulse = -100;
    logic [7:0] txq[$];
    int         pcyc[$];
    always @(posedge clk) cyc <= cyc + 1;
    always @(negedge clk) begin
        if (tx_en === 1'b1) begin
            check("tx_en_while_busy", {31'h0, tx_busy}, 32'h0);
            check("tx_en_gap", (cyc - last_pulse >= 3) ? 32'h1 : 32'h0, 32'h1);
            last_pulse <= cyc;
            txq.push_back(tx_data);
            pcyc.push_back(cyc);
        end
    end

    task automatic wr(input logic [63:0] a, input logic [31:0] d);
        bus.uart_addr = a; bus.uart_write_data = d; bus.uart_wen = 1'b1;
        @(negedge clk);
        bus.uart_wen = 1'b0;
    endtask

    task automatic rd(input logic [63:0] a, output logic [31:0] d);
        bus.uart_addr = a; bus.uart_ren = 1'b1;
        @(negedge clk);
        bus.uart_ren = 1'b0;
        d = bus.uart_read_data;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic rx_push(input logic [7:0] b);
        rx_data = b; rx_valid = 1'b1;
        @(negedge clk);
        rx_valid = 1'b0;
    endtask

    task automatic wait_tx(input int n, input int budget, input string name);
        int k;
        k = 0;
        while (txq.size() < n && k < budget) begin
            @(negedge clk);
            k++;
        end
        if (txq.size() < n) begin
            total++; bad++;
            $display("FAIL %s: timeout with %0d launches, expected %0d", name, txq.size(), n);
        end
    endtask

    typedef struct {
        bit          is_wr;
        logic [63:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_rd;
        logic        exp_irq;
    } vec_t;

    vec_t        vecs[18];
    logic [31:0] d;
    bit          seen;

    initial begin
        vecs[0]  = '{1'b0, A_STAT, 32'h0,         32'h6, 1'b0};
        vecs[1]  = '{1'b0, A_CTRL, 32'h0,         32'h0, 1'b0};
        vecs[2]  = '{1'b1, A_CTRL, 32'h2,         32'h0, 1'b1};
        vecs[3]  = '{1'b0, A_CTRL, 32'h0,         32'h2, 1'b1};
        vecs[4]  = '{1'b1, A_CTRL, 32'hFFFF_FFFC, 32'h0, 1'b0};
        vecs[5]  = '{1'b0, A_CTRL, 32'h0,         32'h0, 1'b0};
        vecs[6]  = '{1'b1, A_CTRL, 32'h1,         32'h0, 1'b0};
        vecs[7]  = '{1'b0, A_CTRL, 32'h0,         32'h1, 1'b0};
        vecs[8]  = '{1'b0, 64'h2000_0004, 32'h0,  32'h0, 1'b0};
        vecs[9]  = '{1'b0, A_CTRL, 32'h0,         32'h1, 1'b0};
        vecs[10] = '{1'b0, A_RSVD, 32'h0,         32'h0, 1'b0};
        vecs[11] = '{1'b1, A_RSVD, 32'hFFFF_FFFF, 32'h0, 1'b0};
        vecs[12] = '{1'b0, A_CTRL, 32'h0,         32'h1, 1'b0};
        vecs[13] = '{1'b1, 64'h2000_0000, 32'h55, 32'h0, 1'b0};
        vecs[14] = '{1'b1, A_STAT, 32'hFFFF_FFFF, 32'h0, 1'b0};
        vecs[15] = '{1'b0, A_STAT, 32'h0,         32'h6, 1'b0};
        vecs[16] = '{1'b0, A_DATA, 32'h0,         32'h0, 1'b0};
        vecs[17] = '{1'b1, A_CTRL, 32'h0,         32'h0, 1'b0};

        bus.uart_addr = 64'h0; bus.uart_write_data = 32'h0;
        bus.uart_wen = 1'b0; bus.uart_ren = 1'b0;
        rx_data = 8'h0; rx_valid = 1'b0; rx_break = 1'b0;
        idle(3);
        rst_n = 1'b1;
        idle(1);
        check("rst_tx_en", {31'h0, tx_en}, 32'h0);
        check("rst_tx_data", {24'h0, tx_data}, 32'h0);
        check("rst_irq", {31'h0, irq}, 32'h0);
        check("rst_read_data", bus.uart_read_data, 32'h0);

        // Register table.
        for (int i = 0; i < 18; i++) begin
            if (vecs[i].is_wr) wr(vecs[i].addr, vecs[i].wdata);
            else begin
                rd(vecs[i].addr, d);
                check($sformatf("vec%0d_rd", i), d, vecs[i].exp_rd);
            end
            idle(1);
            check($sformatf("vec%0d_irq", i), {31'h0, irq}, {31'h0, vecs[i].exp_irq});
        end

        // Three bytes launched in order, paced by busy.
        busy_hold = 1'b1;
        wr(A_DATA, 32'h41); wr(A_DATA, 32'h42); wr(A_DATA, 32'h43);
        rd(A_STAT, d); check("tx3_status", d, 32'h0003_0004);
        txq.delete(); pcyc.delete();
        busy_hold = 1'b0;
        wait_tx(3, 200, "tx3_wait");
        idle(20);
        check("tx3_count", txq.size(), 32'd3);
        for (int i = 0; i < 3 && i < txq.size(); i++)
            check($sformatf("tx3_byte%0d", i), {24'h0, txq[i]}, 32'h41 + i);
        rd(A_STAT, d); check("tx3_drained", d, 32'h6);

        // TX overflow: 17 writes while busy, 17th dropped.
        txq.delete(); pcyc.delete();
        busy_hold = 1'b1;
        for (int i = 0; i < 17; i++) wr(A_DATA, 32'h60 + i);
        rd(A_STAT, d); check("txovf_status", d, 32'h0010_0025);
        wr(A_STAT, 32'h20);
        rd(A_STAT, d); check("txovf_w1c", d, 32'h0010_0005);
        busy_hold = 1'b0;
        wait_tx(16, 600, "txovf_wait");
        idle(30);
        check("txovf_count", txq.size(), 32'd16);
        for (int i = 0; i < 16 && i < txq.size(); i++)
            check($sformatf("txovf_byte%0d", i), {24'h0, txq[i]}, 32'h60 + i);
        rd(A_STAT, d); check("txovf_drained", d, 32'h6);

        // uart_tx never goes busy: the WAIT_BUSY timeout sets a 5-cycle launch period.
        txq.delete(); pcyc.delete();
        model_en = 1'b0;
        wr(A_DATA, 32'h91); wr(A_DATA, 32'h92);
        wait_tx(2, 50, "tmo_wait");
        if (pcyc.size() >= 2) check("tmo_gap", pcyc[1] - pcyc[0], 32'd5);
        else                  check("tmo_launches", pcyc.size(), 32'd2);
        model_en = 1'b1;
        idle(10);

        // RX overflow and drain.
        for (int i = 0; i < 17; i++) rx_push(8'(i));
        rd(A_STAT, d); check("rxovf_status", d, 32'h0000_101A);
        for (int i = 0; i < 16; i++) begin
            rd(A_DATA, d); check($sformatf("rx_pop%0d", i), d, i);
        end
        rd(A_DATA, d); check("rx_pop_empty", d, 32'h0);
        rd(A_STAT, d); check("rxovf_sticky", d, 32'h16);
        wr(A_STAT, 32'h10);
        rd(A_STAT, d); check("rxovf_w1c", d, 32'h6);

        // BREAK flag; a set coinciding with its clear wins.
        rx_break = 1'b1; idle(1); rx_break = 1'b0;
        rd(A_STAT, d); check("brk_set", d, 32'h46);
        rx_break = 1'b1; wr(A_STAT, 32'h40); rx_break = 1'b0;
        rd(A_STAT, d); check("brk_set_wins", d, 32'h46);
        wr(A_STAT, 32'h40);
        rd(A_STAT, d); check("brk_clear", d, 32'h6);

        // RX interrupt latency.
        wr(A_CTRL, 32'h1); idle(1);
        check("irq_rx_empty", {31'h0, irq}, 32'h0);
        rx_push(8'h5A);
        check("irq_lat1", {31'h0, irq}, 32'h0);
        idle(1);
        check("irq_lat2", {31'h0, irq}, 32'h1);
        rd(A_DATA, d); check("irq_pop_data", d, 32'h5A);
        check("irq_at_pop", {31'h0, irq}, 32'h1);
        idle(1);
        check("irq_drop", {31'h0, irq}, 32'h0);
        wr(A_CTRL, 32'h0);

        // Push and pop together on an empty FIFO: push only.
        rx_data = 8'h77; rx_valid = 1'b1;
        rd(A_DATA, d);
        rx_valid = 1'b0;
        check("rx_empty_pp_rd", d, 32'h0);
        rd(A_STAT, d); check("rx_empty_pp_status", d, 32'h0000_0102);
        rd(A_DATA, d); check("rx_empty_pp_byte", d, 32'h77);

        // Push and pop together on a full FIFO: both happen, no overflow.
        for (int i = 0; i < 16; i++) rx_push(8'hB0 + 8'(i));
        rx_data = 8'hAA; rx_valid = 1'b1;
        rd(A_DATA, d);
        rx_valid = 1'b0;
        check("rx_full_pp_rd", d, 32'hB0);
        rd(A_STAT, d); check("rx_full_pp_status", d, 32'h0000_100A);
        for (int i = 1; i < 16; i++) begin
            rd(A_DATA, d); check($sformatf("rx_full_pop%0d", i), d, 32'hB0 + i);
        end
        rd(A_DATA, d); check("rx_full_tail", d, 32'hAA);
        rd(A_STAT, d); check("rx_full_drained", d, 32'h6);

        // Reset in the middle of a transmission.
        txq.delete(); pcyc.delete();
        wr(A_DATA, 32'hC1); wr(A_DATA, 32'hC2);
        seen = 1'b0;
        for (int k = 0; k < 20 && !seen; k++) begin
            if (tx_en === 1'b1) seen = 1'b1;
            else @(negedge clk);
        end
        check("rst_mid_launch_seen", {31'h0, seen}, 32'h1);
        #2 rst_n = 1'b0;
        #1 check("rst_mid_tx_en", {31'h0, tx_en}, 32'h0);
        idle(2);
        rst_n = 1'b1;
        idle(25);
        check("rst_mid_launches", txq.size(), 32'd1);
        rd(A_STAT, d); check("rst_mid_status", d, 32'h6);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/uart_mmio_fifo.md
Name: uart_mmio_fifo

Overview:
- Memory-mapped UART front end between the CPU load/store path and the uart_rx/uart_tx cores.
- Buffers CPU-written bytes in a TX FIFO and launches them to uart_tx one at a time, using uart_tx_busy for pacing.
- Captures uart_rx_valid bytes into an RX FIFO that the CPU pops by reading.
- Exposes STATUS and CTRL registers and a level interrupt.

Parameters:
- BASE_ADDR, 64'h1000_0000, base of the 16-byte register window.
- FIFO_DEPTH, 16, entries per FIFO; must be a power of 2 and at least 2.
- PAYLOAD_BITS, 8, UART byte width.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  reset, asynchronous, active-low.
- uart_addr  in  64  CPU byte address.
- uart_write_data  in  32  CPU store data.
- uart_wen  in  1  store strobe, one cycle per access.
- uart_ren  in  1  load strobe, one cycle per access.
- uart_read_data  out  32  load data, registered.
- tx_data  out  PAYLOAD_BITS  byte to uart_tx.
- tx_en  out  1  one-cycle launch pulse to uart_tx.
- tx_busy  in  1  uart_tx busy.
- rx_data  in  PAYLOAD_BITS  byte from uart_rx.
- rx_valid  in  1  uart_rx byte valid, one-cycle pulse.
- rx_break  in  1  uart_rx BREAK detected.
- irq  out  1  level interrupt.

Behaviour:
- Reset (async assert, sync deassert is the integrator's responsibility): both FIFOs empty; all sticky bits 0; CTRL = 0; uart_read_data = 0; tx_en = 0; tx_data = 0; irq = 0; TX FSM = IDLE.
- Decode: hit when uart_addr[63:4] == BASE_ADDR[63:4]. Offset = uart_addr[3:0].
  - 0x0 DATA
  - 0x4 STATUS
  - 0x8 CTRL
  - 0xC reserved: reads 0, writes ignored.
  - A miss is ignored and uart_read_data is driven to 0 on the next cycle.
- uart_wen and uart_ren are never asserted together; if both are high, the write wins and the read is dropped.
- DATA write: push uart_write_data[7:0] into the TX FIFO. If the TX FIFO is full, the byte is dropped and tx_ovf (sticky) is set.
- DATA read: uart_read_data = {24'b0, RX head} on the cycle after uart_ren, and the head is popped. If the RX FIFO is empty, the read returns 0, nothing is popped, and no error is flagged.
- STATUS read, bit layout:
  - [0] tx_full
  - [1] tx_empty
  - [2] rx_empty
  - [3] rx_full
  - [4] rx_ovf
  - [5] tx_ovf
  - [6] rx_brk
  - [15:8] rx_count
  - [23:16] tx_count
  - other bits 0
- STATUS write: W1C on bits [6:4]; a write to any other bit has no effect. If a set event and a clear land in the same cycle, the set wins.
- CTRL, read/write: [0] rx_ie, [1] tx_ie; other bits read 0.
- irq = (rx_ie & ~rx_empty) | (tx_ie & tx_empty), registered with one cycle latency.
- RX path:
  - rx_valid pushes rx_data. When the FIFO is full, the byte is dropped and rx_ovf is set.
  - A push and a CPU pop in the same cycle are both performed, including when full (pop frees the slot, push accepted, count unchanged). Same-cycle push and pop on an empty FIFO: push only; the read returns 0.
  - rx_break sets rx_brk and pushes nothing.
- TX FSM:
  - IDLE: if the TX FIFO is non-empty and tx_busy == 0, drive tx_data = head and tx_en = 1 for exactly one cycle, pop the head, go to WAIT_BUSY.
  - WAIT_BUSY: wait for tx_busy == 1, then go to WAIT_DONE. A 4-cycle timeout returns to IDLE so a launch missed by uart_tx cannot hang the FSM.
  - WAIT_DONE: wait for tx_busy == 0, then go to IDLE.
  - Minimum gap between tx_en pulses is 3 cycles. tx_en is never asserted while tx_busy == 1.
  - A CPU push in the same cycle as an FSM pop is allowed at any fill level.
- FIFO: pointers are log2(FIFO_DEPTH)+1 bits wide, wrapping modulo 2*FIFO_DEPTH. Full and empty are derived from the MSB and lower pointer bits. Counts saturate naturally at FIFO_DEPTH.
- Reset mid-frame: the FSM returns to IDLE, FIFOs are flushed, and tx_en is low immediately. The frame already in uart_tx is that block's concern.

Decomposition:
- Package uart_mmio_pkg:
  - offsets OFF_DATA/OFF_STATUS/OFF_CTRL
  - STATUS bit index constants
  - CTRL bit index constants
  - TX FSM state enum {IDLE, WAIT_BUSY, WAIT_DONE}
  - WAIT_BUSY timeout constant 4
- Sub-module sync_fifo (params WIDTH, DEPTH; ports push, pop, din, dout, full, empty, count). Instantiated twice: once for RX, once for TX.

Test Plan:
- Reset, then read STATUS -> 32'h0000_0006 (tx_empty, rx_empty); irq = 0.
- Write DATA 0x41, 0x42, 0x43 with tx_busy modelled as 10 cycles high starting 1 cycle after tx_en -> exactly three tx_en pulses carrying 0x41, 0x42, 0x43 in order; no pulse while busy; STATUS tx_count 3 -> 0.
- Fill TX with 17 writes while tx_busy is held 1 -> STATUS[5] = 1, tx_count = 16, and the 17th byte is never transmitted. Write STATUS with 0x20 -> bit 5 clears.
- Pulse rx_valid 17 times with bytes 0x00..0x10 -> rx_ovf = 1, rx_count = 16. DATA reads return 0x00..0x0F, then 0 once empty.
- CTRL = 1 with the RX FIFO empty -> irq = 0. One rx_valid with 0x5A -> irq = 1 two cycles later. Read DATA -> 0x5A, and irq drops one cycle after the pop.
- RX full: same-cycle rx_valid 0xAA and DATA read -> read returns the old head, rx_count stays 16, rx_ovf stays 0, and 0xAA is at the tail. Then assert rst_n = 0 mid-TX -> tx_en = 0 and STATUS = 0x06 after release.
